// File: rtl/branch_seq_pkg.sv
// branch_seq_pkg: shared definitions for the branch sequencer.
//   WORD             default datapath / PC width
//   B_EQ .. B_LTZ    branch condition encodings carried on branch_op
//   state_e          sequencer FSM states
//   branch_offset()  instruction offset field scaled to a byte offset
package branch_seq_pkg;

    localparam int unsigned WORD = 32;

    localparam logic [3:0] B_EQ  = 4'd0;
    localparam logic [3:0] B_NE  = 4'd1;
    localparam logic [3:0] B_GTZ = 4'd2;
    localparam logic [3:0] B_LEZ = 4'd3;
    localparam logic [3:0] B_GEZ = 4'd4;
    localparam logic [3:0] B_LTZ = 4'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVAL,
        S_TARGET,
        S_RESP
    } state_e;

    // Word offset -> byte offset; bit 17 is the sign for later extension.
    function automatic logic [17:0] branch_offset(input logic [15:0] imm);
        return {imm, 2'b00};
    endfunction

endpackage

// File: rtl/branch_seq_if.sv
// branch_seq_if: request/response and statistics bundle between the
// control unit (master) and the branch sequencer (slave).
//   req_valid/req_ready    request handshake; operands pc_plus4, src_a, src_b, imm, branch_op
//   resp_valid/resp_ready  response handshake; results taken, next_pc, illegal
//   clr_stats              synchronous clear of the statistics counters
//   cnt_total/cnt_taken    saturating statistics counters
interface branch_seq_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) ();

    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [15:0]      imm;
    logic [3:0]       branch_op;
    logic             resp_valid;
    logic             resp_ready;
    logic             taken;
    logic [WIDTH-1:0] next_pc;
    logic             illegal;
    logic             clr_stats;
    logic [CNT_W-1:0] cnt_total;
    logic [CNT_W-1:0] cnt_taken;

    modport master (
        output req_valid, pc_plus4, src_a, src_b, imm, branch_op, resp_ready, clr_stats,
        input  req_ready, resp_valid, taken, next_pc, illegal, cnt_total, cnt_taken
    );

    modport slave (
        input  req_valid, pc_plus4, src_a, src_b, imm, branch_op, resp_ready, clr_stats,
        output req_ready, resp_valid, taken, next_pc, illegal, cnt_total, cnt_taken
    );

endinterface

// File: rtl/branch_cond.sv
// branch_cond: combinational branch condition evaluator.
//   a_i, b_i   operands (two's complement)
//   op_i       condition code (B_* encodings)
//   taken_o    condition holds
//   illegal_o  op_i is not a defined code (taken_o forced low)
module branch_cond
    import branch_seq_pkg::*;
#(
    parameter int unsigned Width = 32
) (
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  logic [3:0]       op_i,
    output logic             taken_o,
    output logic             illegal_o
);

    // Signed compares against zero reduce to sign bit and zero detect.
    logic a_neg;
    logic a_zero;

    assign a_neg  = a_i[Width-1];
    assign a_zero = (a_i == '0);

    always_comb begin
        taken_o   = 1'b0;
        illegal_o = 1'b0;
        case (op_i)
            B_EQ:    taken_o = (a_i == b_i);
            B_NE:    taken_o = (a_i != b_i);
            B_GTZ:   taken_o = !a_neg && !a_zero;
            B_LEZ:   taken_o = a_neg || a_zero;
            B_GEZ:   taken_o = !a_neg;
            B_LTZ:   taken_o = a_neg;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_seq.sv
// branch_seq: multi-cycle branch sequencer (IDLE -> EVAL -> TARGET -> RESP).
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset; drops any request in flight
//   bus    branch_seq_if slave: request in, taken/next_pc/illegal out, stats counters
// Accepts one request in IDLE, evaluates the condition, forms the target and
// holds the result until the control unit takes it. WIDTH must exceed 18.
module branch_seq
    import branch_seq_pkg::*;
#(
    parameter int unsigned WIDTH = WORD,
    parameter int unsigned CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    branch_seq_if.slave  bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [15:0]      imm_q, imm_d;
    logic [3:0]       op_q, op_d;
    logic             taken_q, taken_d;
    logic             illegal_q, illegal_d;
    logic [WIDTH-1:0] next_pc_q, next_pc_d;
    logic [CNT_W-1:0] cnt_total_q, cnt_total_d;
    logic [CNT_W-1:0] cnt_taken_q, cnt_taken_d;

    logic             cond_taken;
    logic             cond_illegal;
    logic [17:0]      offset;
    logic [WIDTH-1:0] target;
    logic             resp_hs;

    branch_cond #(
        .Width (WIDTH)
    ) u_cond (
        .a_i       (a_q),
        .b_i       (b_q),
        .op_i      (op_q),
        .taken_o   (cond_taken),
        .illegal_o (cond_illegal)
    );

    // Target wraps modulo 2^WIDTH.
    assign offset  = branch_offset(imm_q);
    assign target  = pc_q + {{(WIDTH-18){offset[17]}}, offset};
    assign resp_hs = (state_q == S_RESP) && bus.resp_ready;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        a_d       = a_q;
        b_d       = b_q;
        imm_d     = imm_q;
        op_d      = op_q;
        taken_d   = taken_q;
        illegal_d = illegal_q;
        next_pc_d = next_pc_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    pc_d    = bus.pc_plus4;
                    a_d     = bus.src_a;
                    b_d     = bus.src_b;
                    imm_d   = bus.imm;
                    op_d    = bus.branch_op;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                taken_d   = cond_taken;
                illegal_d = cond_illegal;
                state_d   = S_TARGET;
            end
            S_TARGET: begin
                next_pc_d = taken_q ? target : pc_q;
                state_d   = S_RESP;
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Clear beats a coincident handshake; increments stick at all-ones.
    always_comb begin
        cnt_total_d = cnt_total_q;
        cnt_taken_d = cnt_taken_q;
        if (bus.clr_stats) begin
            cnt_total_d = '0;
            cnt_taken_d = '0;
        end else if (resp_hs) begin
            if (cnt_total_q != '1) begin
                cnt_total_d = cnt_total_q + 1'b1;
            end
            if (taken_q && (cnt_taken_q != '1)) begin
                cnt_taken_d = cnt_taken_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            imm_q       <= '0;
            op_q        <= '0;
            taken_q     <= 1'b0;
            illegal_q   <= 1'b0;
            next_pc_q   <= '0;
            cnt_total_q <= '0;
            cnt_taken_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            a_q         <= a_d;
            b_q         <= b_d;
            imm_q       <= imm_d;
            op_q        <= op_d;
            taken_q     <= taken_d;
            illegal_q   <= illegal_d;
            next_pc_q   <= next_pc_d;
            cnt_total_q <= cnt_total_d;
            cnt_taken_q <= cnt_taken_d;
        end
    end

    // Handshake flags come from the state register only.
    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.taken      = taken_q;
    assign bus.illegal    = illegal_q;
    assign bus.next_pc    = next_pc_q;
    assign bus.cnt_total  = cnt_total_q;
    assign bus.cnt_taken  = cnt_taken_q;

endmodule

// File: tb/tb_branch_seq.sv
// tb_branch_seq: directed bench for branch_seq; counters narrowed to 6 bits
// so saturation is reachable in a short run.
module tb_branch_seq;
    import branch_seq_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 6;
    localparam logic [31:0] CNT_MAX = 32'd63;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    branch_seq_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    branch_seq #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction with resp_ready high; optional clear on the handshake.
    task automatic run(input string tag, input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b, input logic [15:0] imm, input logic [3:0] op,
                       input logic exp_taken, input logic [31:0] exp_pc,
                       input logic exp_ill, input bit clr,
                       input logic [31:0] exp_tot, input logic [31:0] exp_tkn);
        chk({tag, ".req_ready"}, {31'd0, bus.req_ready}, 32'd1);
        bus.pc_plus4  = pc;
        bus.src_a     = a;
        bus.src_b     = b;
        bus.imm       = imm;
        bus.branch_op = op;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        chk({tag, ".eval_valid"}, {31'd0, bus.resp_valid}, 32'd0);
        tick();
        tick();
        chk({tag, ".resp_valid"}, {31'd0, bus.resp_valid}, 32'd1);
        chk({tag, ".taken"}, {31'd0, bus.taken}, {31'd0, exp_taken});
        chk({tag, ".next_pc"}, bus.next_pc, exp_pc);
        chk({tag, ".illegal"}, {31'd0, bus.illegal}, {31'd0, exp_ill});
        bus.clr_stats = clr;
        tick();
        bus.clr_stats = 1'b0;
        chk({tag, ".after_valid"}, {31'd0, bus.resp_valid}, 32'd0);
        chk({tag, ".cnt_total"}, 32'(bus.cnt_total), exp_tot);
        chk({tag, ".cnt_taken"}, 32'(bus.cnt_taken), exp_tkn);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.pc_plus4  = '0;
        bus.src_a     = '0;
        bus.src_b     = '0;
        bus.imm       = '0;
        bus.branch_op = B_EQ;
        bus.resp_ready = 1'b1;
        bus.clr_stats = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst.req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst.resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst.taken", {31'd0, bus.taken}, 32'd0);
        chk("rst.illegal", {31'd0, bus.illegal}, 32'd0);
        chk("rst.next_pc", bus.next_pc, 32'd0);
        chk("rst.cnt_total", 32'(bus.cnt_total), 32'd0);
        chk("rst.cnt_taken", 32'(bus.cnt_taken), 32'd0);
        rst_n = 1'b1;
        tick();

        // Reset asserted mid-EVAL drops the request
        bus.src_a     = 32'd7;
        bus.src_b     = 32'd7;
        bus.imm       = 16'h0001;
        bus.pc_plus4  = 32'h0000_0100;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        chk("mid.in_eval_ready", {31'd0, bus.req_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid.req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("mid.resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("mid.cnt_total", 32'(bus.cnt_total), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mid.no_resp", {31'd0, bus.resp_valid}, 32'd0);
        end

        // Main function
        run("beq", 32'h0040_0004, 32'd5, 32'd5, 16'h0003, B_EQ,
            1'b1, 32'h0040_0010, 1'b0, 1'b0, 32'd1, 32'd1);
        run("bltz_t", 32'h0040_0020, 32'hFFFF_FFFF, 32'd0, 16'hFFFE, B_LTZ,
            1'b1, 32'h0040_0018, 1'b0, 1'b0, 32'd2, 32'd2);
        run("bltz_nt", 32'h0040_0020, 32'h7FFF_FFFF, 32'd0, 16'hFFFE, B_LTZ,
            1'b0, 32'h0040_0020, 1'b0, 1'b0, 32'd3, 32'd2);

        // Back-pressure: result held, second request ignored
        bus.resp_ready = 1'b0;
        bus.pc_plus4   = 32'h0000_1000;
        bus.src_a      = 32'd1;
        bus.src_b      = 32'd2;
        bus.imm        = 16'h0010;
        bus.branch_op  = B_NE;
        bus.req_valid  = 1'b1;
        tick();
        bus.req_valid  = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp.resp_valid", {31'd0, bus.resp_valid}, 32'd1);
            chk("bp.taken", {31'd0, bus.taken}, 32'd1);
            chk("bp.next_pc", bus.next_pc, 32'h0000_1040);
            chk("bp.req_ready", {31'd0, bus.req_ready}, 32'd0);
            bus.req_valid = (i == 2);
            bus.branch_op = B_EQ;
            tick();
        end
        bus.req_valid  = 1'b0;
        chk("bp.cnt_stall", 32'(bus.cnt_total), 32'd3);
        bus.resp_ready = 1'b1;
        tick();
        chk("bp.released", {31'd0, bus.resp_valid}, 32'd0);
        chk("bp.cnt_total", 32'(bus.cnt_total), 32'd4);
        chk("bp.cnt_taken", 32'(bus.cnt_taken), 32'd3);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp.no_second", {31'd0, bus.resp_valid}, 32'd0);
        end

        // Signed zero boundaries
        run("bgtz0", 32'h0000_0100, 32'd0, 32'd0, 16'h0001, B_GTZ,
            1'b0, 32'h0000_0100, 1'b0, 1'b0, 32'd5, 32'd3);
        run("blez0", 32'h0000_0100, 32'd0, 32'd0, 16'h0001, B_LEZ,
            1'b1, 32'h0000_0104, 1'b0, 1'b0, 32'd6, 32'd4);
        run("bgez_min", 32'h0000_0100, 32'h8000_0000, 32'd0, 16'h0001, B_GEZ,
            1'b0, 32'h0000_0100, 1'b0, 1'b0, 32'd7, 32'd4);

        // Undefined condition code
        run("illegal", 32'h0000_0200, 32'd0, 32'd0, 16'h0005, 4'hF,
            1'b0, 32'h0000_0200, 1'b1, 1'b0, 32'd8, 32'd4);

        // Target wraps past the top of the address space
        run("wrap", 32'hFFFF_FFFC, 32'd3, 32'd3, 16'h0002, B_EQ,
            1'b1, 32'h0000_0004, 1'b0, 1'b0, 32'd9, 32'd5);

        // Clear coinciding with a handshake wins
        run("clr_hs", 32'h0000_0300, 32'd1, 32'd1, 16'h0001, B_EQ,
            1'b1, 32'h0000_0304, 1'b0, 1'b1, 32'd0, 32'd0);

        // Saturation: 63 taken fill both counters, further ones stick
        for (int i = 0; i < 64; i++) begin
            run("sat", 32'h0000_0000, 32'd0, 32'd0, 16'h0001, B_EQ,
                1'b1, 32'h0000_0004, 1'b0, 1'b0,
                (i < 63) ? 32'(i + 1) : CNT_MAX, (i < 63) ? 32'(i + 1) : CNT_MAX);
        end
        run("sat_nt", 32'h0000_0000, 32'd0, 32'd1, 16'h0001, B_EQ,
            1'b0, 32'h0000_0000, 1'b0, 1'b0, CNT_MAX, CNT_MAX);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
